dma_mem_slave: RTL and testbench

Word-organised memory target that sits directly downstream of the DMA controller and answers its `mem_read`/`mem_write`/`mem_ready` handshake. It decodes the byte address, inserts a programmable number of wait states, performs the read or write, and flags errors for unaligned, out-of-window or conflicting requests. A side-band backdoor port lets benches preload and inspect contents without using the bus.

---
 rtl/dma_mem_pkg.sv | 16 +
 rtl/dma_mem_array.sv | 62 ++++++
 rtl/dma_mem_slave.sv | 145 ++++++++++++++
 tb/tb_dma_mem_slave.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_mem_pkg.sv
// Shared types and constants for the DMA-facing memory target.
//   state_t   : bus FSM states
//   ERR_RDATA : read data returned on an errored completion
//   WS_CNT_W  : width of the wait-state counter (0..15 wait states)
package dma_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;
    localparam int          WS_CNT_W  = 4;

endpackage

// File: rtl/dma_mem_array.sv
// Dual-port synchronous word RAM behind the DMA memory target.
//   clk, reset          : clock; reset clears only the read registers
//   a_re/a_we/a_clr     : bus port read, write, and error-completion clear
//   a_idx/a_wdata       : bus port word index and write data
//   a_rdata             : bus port read register (write-first)
//   b_en/b_we/b_idx     : backdoor enable, write, word index
//   b_wdata/b_rdata     : backdoor write data and read register (read-old)
module dma_mem_array
    import dma_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_re,
    input  logic                  a_we,
    input  logic                  a_clr,
    input  logic [DEPTH_LOG2-1:0] a_idx,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [DEPTH_LOG2-1:0] b_idx,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata
);

    logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

    // The bus write is issued last so it wins a same-index collision with
    // the backdoor.
    always_ff @(posedge clk) begin
        if (b_en && b_we) begin
            mem[b_idx] <= b_wdata;
        end
        if (a_we) begin
            mem[a_idx] <= a_wdata;
        end
    end

    // Only reads and error completions touch the bus read register, so it
    // holds the last read value across writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata <= '0;
        end else if (a_clr) begin
            a_rdata <= DATA_W'(ERR_RDATA);
        end else if (a_re) begin
            a_rdata <= a_we ? a_wdata : mem[a_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b_rdata <= '0;
        end else if (b_en && !b_we) begin
            b_rdata <= mem[b_idx];
        end
    end

endmodule

// File: rtl/dma_mem_slave.sv
// Word-organised memory target answering the DMA mem_read/mem_write/
// mem_ready handshake, with programmable wait states and error flagging.
//   clk, reset            : clock, synchronous active-high reset
//   mem_addr/mem_wdata    : byte address and write data from the DMA
//   mem_read/mem_write    : level requests, held until mem_ready
//   mem_rdata             : read data, valid with mem_ready
//   mem_ready/mem_err     : one-cycle completion pulse and its error flag
//   bd_en/bd_we/bd_idx    : backdoor enable, write, word index
//   bd_wdata/bd_rdata     : backdoor write data, read data (1-cycle latency)
//
// state | meaning
// IDLE  | waiting for a request; captures address/data/op
// WAIT  | counting wait states; executes on the last one
// RESP  | mem_ready asserted for one cycle
module dma_mem_slave
    import dma_mem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_LOG2  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_err,
    input  logic                  bd_en,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_idx,
    input  logic [DATA_W-1:0]     bd_wdata,
    output logic [DATA_W-1:0]     bd_rdata
);

    localparam logic [ADDR_W-1:0]   WIN_BYTES = ADDR_W'(1) << (DEPTH_LOG2 + 2);
    // Unused when WAIT_STATES is 0 (WAIT is never entered).
    localparam logic [WS_CNT_W-1:0] WS_LAST   = WS_CNT_W'(WAIT_STATES - 1);

    state_t                state, state_n;
    logic [WS_CNT_W-1:0]   cnt, cnt_n;
    logic                  capture, exec;

    logic [ADDR_W-1:0]     off;
    logic                  in_err;
    logic [DEPTH_LOG2-1:0] in_idx;

    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  we_q, err_q;

    logic [DEPTH_LOG2-1:0] x_idx;
    logic [DATA_W-1:0]     x_wdata;
    logic                  x_we, x_err;

    assign off    = mem_addr - BASE_ADDR;
    assign in_idx = off[DEPTH_LOG2+1:2];
    assign in_err = (mem_addr[1:0] != 2'b00) || (mem_addr < BASE_ADDR) ||
                    (off >= WIN_BYTES) || (mem_read && mem_write);

    // With zero wait states the access executes on the capture edge, so the
    // live inputs feed the array instead of the captured copies.
    assign x_idx   = (state == IDLE) ? in_idx    : idx_q;
    assign x_wdata = (state == IDLE) ? mem_wdata : wdata_q;
    assign x_we    = (state == IDLE) ? mem_write : we_q;
    assign x_err   = (state == IDLE) ? in_err    : err_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        exec    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    capture = 1'b1;
                    cnt_n   = '0;
                    if (WAIT_STATES == 0) begin
                        exec    = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == WS_LAST) begin
                    exec    = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + WS_CNT_W'(1);
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                idx_q   <= in_idx;
                wdata_q <= mem_wdata;
                we_q    <= mem_write;
                err_q   <= in_err;
            end
        end
    end

    assign mem_ready = (state == RESP);
    assign mem_err   = (state == RESP) && err_q;

    dma_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .a_re    (exec && !x_we && !x_err && !reset),
        .a_we    (exec &&  x_we && !x_err && !reset),
        .a_clr   (exec &&  x_err && !reset),
        .a_idx   (x_idx),
        .a_wdata (x_wdata),
        .a_rdata (mem_rdata),
        .b_en    (bd_en),
        .b_we    (bd_we),
        .b_idx   (bd_idx),
        .b_wdata (bd_wdata),
        .b_rdata (bd_rdata)
    );

endmodule

// File: tb/tb_dma_mem_slave.sv
// Bench for dma_mem_slave: three instances with 1, 0 and 3 wait states.
// Expected completions are queued when a request is issued and compared
// when mem_ready appears.
module tb_dma_mem_slave;
    import dma_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] addr[3], wdata[3], rdata[3], bd_wdata[3], bd_rdata[3];
    logic        rd[3], wr[3], ready[3], err[3], bd_en[3], bd_we[3];
    logic [7:0]  bd_idx[3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rd[3];
    int          n_tests = 0;
    int          n_fail  = 0;

    dma_mem_slave #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_read(rd[0]), .mem_write(wr[0]), .mem_rdata(rdata[0]),
        .mem_ready(ready[0]), .mem_err(err[0]), .bd_en(bd_en[0]), .bd_we(bd_we[0]),
        .bd_idx(bd_idx[0]), .bd_wdata(bd_wdata[0]), .bd_rdata(bd_rdata[0]));

    dma_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_read(rd[1]), .mem_write(wr[1]), .mem_rdata(rdata[1]),
        .mem_ready(ready[1]), .mem_err(err[1]), .bd_en(bd_en[1]), .bd_we(bd_we[1]),
        .bd_idx(bd_idx[1]), .bd_wdata(bd_wdata[1]), .bd_rdata(bd_rdata[1]));

    dma_mem_slave #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_read(rd[2]), .mem_write(wr[2]), .mem_rdata(rdata[2]),
        .mem_ready(ready[2]), .mem_err(err[2]), .bd_en(bd_en[2]), .bd_we(bd_we[2]),
        .bd_idx(bd_idx[2]), .bd_wdata(bd_wdata[2]), .bd_rdata(bd_rdata[2]));

    // Issue one bus access on instance d. exp_lat counts edges from issue
    // (first edge is the capture for an idle FSM) to the one after which
    // mem_ready is seen. hold=1 returns right at the completion so the next
    // call retargets the request back-to-back.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd_data, input logic exp_err,
                          input int exp_lat, input bit hold, output int rcyc);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        e.d   = d;
        e.err = exp_err;
        e.lat = exp_lat;
        if (exp_err)  e.rdata = 32'h0;
        else if (r)   e.rdata = rd_data;
        else          e.rdata = model_rd[d];
        model_rd[d] = e.rdata;
        sb.push_back(e);
        addr[d] = a; wdata[d] = wd; rd[d] = r; wr[d] = w;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready[d] === 1'b1) seen = 1'b1;
        end
        rcyc = cyc;
        got  = sb.pop_front();
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout dut%0d addr=%h: mem_ready not seen within %0d cycles", got.d, a, n);
        end else begin
            n_tests++;
            if (n !== got.lat) begin
                n_fail++;
                $display("FAIL latency dut%0d addr=%h: got %0d want %0d", got.d, a, n, got.lat);
            end
            n_tests++;
            if (err[d] !== got.err) begin
                n_fail++;
                $display("FAIL mem_err dut%0d addr=%h: got %b want %b", got.d, a, err[d], got.err);
            end
            n_tests++;
            if (rdata[d] !== got.rdata) begin
                n_fail++;
                $display("FAIL mem_rdata dut%0d addr=%h: got %h want %h", got.d, a, rdata[d], got.rdata);
            end
        end
        if (!hold) begin
            rd[d] = 1'b0; wr[d] = 1'b0;
            @(posedge clk); #1;
            n_tests++;
            if (ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_pulse dut%0d: mem_ready got %b want 0 after completion", d, ready[d]);
            end
        end
    endtask

    task automatic bd_write(input int d, input logic [7:0] i, input logic [31:0] v);
        bd_en[d] = 1'b1; bd_we[d] = 1'b1; bd_idx[d] = i; bd_wdata[d] = v;
        @(posedge clk); #1;
        bd_en[d] = 1'b0; bd_we[d] = 1'b0;
    endtask

    task automatic bd_read(input int d, input logic [7:0] i, output logic [31:0] v);
        bd_en[d] = 1'b1; bd_we[d] = 1'b0; bd_idx[d] = i;
        @(posedge clk); #1;
        v = bd_rdata[d];
        bd_en[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (ready[d] !== 1'b0 || err[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: ready=%b err=%b want 0 0", d, ready[d], err[d]);
            end
            n_tests++;
            if (rdata[d] !== 32'h0 || bd_rdata[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data dut%0d: rdata=%h bd_rdata=%h want 0 0", d, rdata[d], bd_rdata[d]);
            end
            model_rd[d] = 32'h0;
        end
        n_tests++;
        if (u_ws1.state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want IDLE", u_ws1.state);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backdoor_preload();
        logic [31:0] pre[4];
        int rc;
        pre = '{32'hAAAA1111, 32'hBBBB2222, 32'hCCCC3333, 32'hDDDD4444};
        for (int i = 0; i < 4; i++) bd_write(0, 8'(4 + i), pre[i]);
        for (int i = 0; i < 4; i++)
            access(0, 1'b1, 1'b0, 32'(32'h10 + 4 * i), 32'h0, pre[i], 1'b0, 2, 1'b0, rc);
    endtask

    task automatic test_write_read();
        logic [31:0] v;
        int rc;
        access(0, 1'b0, 1'b1, 32'h100, 32'h12345678, 32'h0, 1'b0, 2, 1'b1, rc);
        access(0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678, 1'b0, 3, 1'b0, rc);
        bd_read(0, 8'd64, v);
        n_tests++;
        if (v !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bd_idx64: got %h want 12345678", v);
        end
    endtask

    task automatic test_errors();
        logic [31:0] v;
        int rc;
        bd_write(0, 8'd0, 32'h00C0FFEE);
        access(0, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 2, 1'b0, rc);
        access(0, 1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, 32'h0, 1'b1, 2, 1'b0, rc);
        bd_read(0, 8'd0, v);
        n_tests++;
        if (v !== 32'h00C0FFEE) begin
            n_fail++;
            $display("FAIL err_no_write_oow: idx0 got %h want 00c0ffee", v);
        end
        access(0, 1'b1, 1'b1, 32'h14, 32'h55555555, 32'h0, 1'b1, 2, 1'b0, rc);
        bd_read(0, 8'd5, v);
        n_tests++;
        if (v !== 32'hBBBB2222) begin
            n_fail++;
            $display("FAIL err_no_write_rw: idx5 got %h want bbbb2222", v);
        end
        access(0, 1'b1, 1'b0, 32'h18, 32'h0, 32'hCCCC3333, 1'b0, 2, 1'b0, rc);
    endtask

    task automatic test_wait_states();
        int ws, r1, r2, rc;
        logic [31:0] v;
        for (int d = 1; d < 3; d++) begin
            ws = (d == 1) ? 0 : 3;
            v  = 32'hA5A50000 + 32'(d);
            access(d, 1'b0, 1'b1, 32'h40, v, 32'h0, 1'b0, ws + 1, 1'b0, rc);
            access(d, 1'b1, 1'b0, 32'h40, 32'h0, v, 1'b0, ws + 1, 1'b1, r1);
            access(d, 1'b1, 1'b0, 32'h40, 32'h0, v, 1'b0, ws + 2, 1'b0, r2);
            n_tests++;
            if (r2 - r1 !== ws + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing dut%0d: got %0d want %0d", d, r2 - r1, ws + 2);
            end
        end
    endtask

    // Zero-wait-state instance executes on the capture edge, so the bus
    // write and the backdoor access land on the same edge.
    task automatic test_backdoor_conflict();
        logic [31:0] v;
        bd_write(1, 8'd10, 32'h11111111);
        addr[1] = 32'h28; wdata[1] = 32'h22222222; wr[1] = 1'b1; rd[1] = 1'b0;
        bd_en[1] = 1'b1; bd_we[1] = 1'b0; bd_idx[1] = 8'd10;
        @(posedge clk); #1;
        n_tests++;
        if (bd_rdata[1] !== 32'h11111111 || ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bd_read_old: bd_rdata=%h ready=%b want 11111111 1", bd_rdata[1], ready[1]);
        end
        wr[1] = 1'b0; bd_en[1] = 1'b0;
        @(posedge clk); #1;
        bd_read(1, 8'd10, v);
        n_tests++;
        if (v !== 32'h22222222) begin
            n_fail++;
            $display("FAIL bd_after_bus_write: got %h want 22222222", v);
        end
        addr[1] = 32'h2C; wdata[1] = 32'h33333333; wr[1] = 1'b1;
        bd_en[1] = 1'b1; bd_we[1] = 1'b1; bd_idx[1] = 8'd11; bd_wdata[1] = 32'h44444444;
        @(posedge clk); #1;
        wr[1] = 1'b0; bd_en[1] = 1'b0; bd_we[1] = 1'b0;
        @(posedge clk); #1;
        bd_read(1, 8'd11, v);
        n_tests++;
        if (v !== 32'h33333333) begin
            n_fail++;
            $display("FAIL ww_conflict: got %h want 33333333", v);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] v;
        int bad;
        bd_write(0, 8'd8, 32'h88888888);
        addr[0] = 32'h20; wdata[0] = 32'hDEADBEEF; wr[0] = 1'b1; rd[0] = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (u_ws1.state !== WAIT) begin
            n_fail++;
            $display("FAIL mid_state: got %0d want WAIT", u_ws1.state);
        end
        reset = 1'b1; wr[0] = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (ready[0] !== 1'b0 || u_ws1.state !== IDLE || rdata[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b state=%0d rdata=%h want 0 IDLE 0", ready[0], u_ws1.state, rdata[0]);
        end
        reset = 1'b0;
        for (int d = 0; d < 3; d++) model_rd[d] = 32'h0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready[0] !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abandoned_ready: mem_ready seen %0d times want 0", bad);
        end
        bd_read(0, 8'd8, v);
        n_tests++;
        if (v !== 32'h88888888) begin
            n_fail++;
            $display("FAIL reset_no_write: idx8 got %h want 88888888", v);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            addr[d] = '0; wdata[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
            bd_en[d] = 1'b0; bd_we[d] = 1'b0; bd_idx[d] = '0; bd_wdata[d] = '0;
            model_rd[d] = '0;
        end
        test_reset();
        test_backdoor_preload();
        test_write_read();
        test_errors();
        test_wait_states();
        test_backdoor_conflict();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
